seg7_scan_drv: RTL

//   Multiplexed seven-segment display driver downstream of the system clock divider.

---
 rtl/seg7_scan_drv_if.sv | 13 +
 rtl/seg7_scan_drv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_drv_if.sv
// Load channel for the seven-segment scan driver: a display word plus
// decimal points, moved with a valid/ready handshake.
interface seg7_scan_drv_if #(
  parameter int NUM_DIG = 8
);
  logic [4*NUM_DIG-1:0] data_in;
  logic [NUM_DIG-1:0]   dp_in;
  logic                 load_valid;
  logic                 load_ready;

  modport master (output data_in, output dp_in, output load_valid, input load_ready);
  modport slave  (input data_in, input dp_in, input load_valid, output load_ready);
endinterface

// File: rtl/seg7_scan_drv.sv
// Multiplexed seven-segment driver. One digit is stepped per rising edge of
// the 1 kHz strobe. All anodes stay dark for BLANK_CYC cycles between digits
// so that the previous segment pattern never ghosts onto the next anode.
// New words are staged in a pending register and swapped in only when the
// scan wraps, so a frame never shows a mix of old and new digits.
module seg7_scan_drv #(
  parameter int NUM_DIG   = 8,
  parameter int BLANK_CYC = 50
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               clk_1k,
  input  logic               blank_lz,
  seg7_scan_drv_if.slave     ld,
  output logic [NUM_DIG-1:0] an_n,
  output logic [6:0]         seg_n,
  output logic               dp_n,
  output logic               frame_done
);

  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int DW = 4 * NUM_DIG;
  localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_DIG - 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(BLANK_CYC - 1);
  localparam logic [NUM_DIG-1:0] AN_ONE   = NUM_DIG'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DW-1:0]      act_data_q, act_data_d;
  logic [DW-1:0]      pend_data_q, pend_data_d;
  logic [NUM_DIG-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIG-1:0] pend_dp_q, pend_dp_d;
  logic               pend_q, pend_d;
  logic               clk_1k_dly_q, clk_1k_dly_d;
  logic [NUM_DIG-1:0] an_n_q, an_n_d;
  logic [6:0]         seg_n_q, seg_n_d;
  logic               dp_n_q, dp_n_d;
  logic               frame_done_q, frame_done_d;

  logic               tick_s;
  logic               blank_end_s;
  logic               step_s;
  logic               boundary_s;
  logic               accept_s;
  logic [DW-1:0]      shifted_s;
  logic [3:0]         cur_nib_s;
  logic               cur_dp_s;
  logic               lz_s;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // clk_1k is already synchronous to clk_in, so one delay flop is enough to find its rising edge.
  assign clk_1k_dly_d = clk_1k;
  assign tick_s       = clk_1k & ~clk_1k_dly_q;
  assign blank_end_s  = (state_q == ST_BLANK) && (cnt_q == CNT_LAST);
  assign step_s       = (state_q == ST_DRIVE) && tick_s;
  assign boundary_s   = step_s && (idx_q == IDX_LAST);
  assign accept_s     = ld.load_valid & ~pend_q;
  assign ld.load_ready = ~pend_q;

  // Bringing the current digit to bit 0 also tells us whether every more-significant nibble is zero.
  assign shifted_s = act_data_q >> {idx_q, 2'b00};
  assign cur_nib_s = shifted_s[3:0];
  assign cur_dp_s  = act_dp_q[idx_q];
  assign lz_s      = blank_lz & (idx_q != '0) & (shifted_s == '0);

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

  // Scan state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave BLANK once the gap has elapsed, leave DRIVE on a strobe edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_LAST) state_d = ST_DRIVE;
        else                   state_d = ST_BLANK;
      end
      ST_DRIVE: begin
        if (tick_s) state_d = ST_BLANK;
        else        state_d = ST_DRIVE;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Scan outputs, gap counter and digit index; a strobe edge during BLANK is deliberately dropped.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    an_n_d       = an_n_q;
    seg_n_d      = seg_n_q;
    dp_n_d       = dp_n_q;
    frame_done_d = 1'b0;
    if (blank_end_s) begin
      an_n_d  = ~(AN_ONE << idx_q);
      seg_n_d = lz_s ? 7'h7F : hex_decode(cur_nib_s);
      dp_n_d  = ~cur_dp_s;
      cnt_d   = '0;
    end else if (state_q == ST_BLANK) begin
      cnt_d = cnt_q + CW'(1);
    end else if (step_s) begin
      idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      an_n_d       = '1;
      seg_n_d      = 7'h7F;
      dp_n_d       = 1'b1;
      cnt_d        = '0;
      frame_done_d = boundary_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Staging: accept into pending while it is free, promote to active only at the frame wrap.
  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    if (boundary_s && pend_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      pend_d     = 1'b0;
    end else if (accept_s) begin
      pend_data_d = ld.data_in;
      pend_dp_d   = ld.dp_in;
      pend_d      = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Datapath and output registers; reset blanks the display and discards any staged word.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      clk_1k_dly_q <= 1'b0;
      an_n_q       <= '1;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      clk_1k_dly_q <= clk_1k_dly_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
